// File: rtl/control_unit.sv
// Multicycle fetch/execute sequencer driving the bus datapath strobes.
// Optional memory wait states are enabled by defining CTRL_MEM_WAIT_EN.
module control_unit #(
  parameter logic [4:0] ADD_OP = 5'b00011
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic        PCout,
  output logic        IncPC,
  output logic        PCin,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Read,
  output logic        Write,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIin,
  output logic        LOin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic [4:0]  OpCode,
  output logic        run,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_NOP, C_ALU, C_IMM, C_LD, C_ST, C_MUL, C_HALT
  } cls_t;

  typedef struct packed {
    logic       PCout, IncPC, PCin, MARin, MDRin, MDRout, Read, Write;
    logic       IRin, Yin, Zin, Zlowout, Zhighout, HIin, LOin;
    logic       Gra, Grb, Grc, Rin, Rout, BAout, Cout;
    logic [4:0] OpCode;
    logic       run;
  } ctrl_t;

  state_t     state, nxt_state;
  cls_t       cls, nxt_cls;
  logic [4:0] op_q, nxt_op;
  ctrl_t      ctrl;
  logic       mem_wait;
  logic       unused_in;

  assign unused_in = ^{ir[26:0], mem_ready};

`ifdef CTRL_MEM_WAIT_EN
  assign mem_wait = ~mem_ready;
`else
  assign mem_wait = 1'b0;
`endif

  function automatic cls_t classify(input logic [4:0] op);
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110,
      5'b00111, 5'b01000, 5'b01001, 5'b01010: classify = C_ALU;
      5'b01100, 5'b01101, 5'b01110:           classify = C_IMM;
      5'b00000:                               classify = C_LD;
      5'b00010:                               classify = C_ST;
      5'b01111, 5'b10000:                     classify = C_MUL;
      5'b11011:                               classify = C_HALT;
      default:                                classify = C_NOP;
    endcase
  endfunction

  // Strobes are a pure function of (state, class, latched opcode).
  function automatic ctrl_t decode(input state_t s, input cls_t c, input logic [4:0] op);
    ctrl_t o;
    o = '0;
    o.run = (s != S_RESET) && (s != S_HALT);
    case (s)
      S_T0: begin o.PCout = 1'b1; o.MARin = 1'b1; o.IncPC = 1'b1; o.Zin = 1'b1; end
      S_T1: begin o.Zlowout = 1'b1; o.PCin = 1'b1; o.Read = 1'b1; o.MDRin = 1'b1; end
      S_T2: begin o.MDRout = 1'b1; o.IRin = 1'b1; end
      S_T3: begin
        o.Yin = 1'b1;
        case (c)
          C_ALU, C_IMM: begin o.Grb = 1'b1; o.Rout = 1'b1; end
          C_LD, C_ST:   begin o.Grb = 1'b1; o.BAout = 1'b1; end
          C_MUL:        begin o.Gra = 1'b1; o.Rout = 1'b1; end
          default:      o.Yin = 1'b0;
        endcase
      end
      S_T4: begin
        o.Zin = 1'b1;
        case (c)
          C_ALU:      begin o.Grc = 1'b1; o.Rout = 1'b1; o.OpCode = op; end
          C_IMM:      begin o.Cout = 1'b1; o.OpCode = op; end
          C_LD, C_ST: begin o.Cout = 1'b1; o.OpCode = ADD_OP; end
          C_MUL:      begin o.Grb = 1'b1; o.Rout = 1'b1; o.OpCode = op; end
          default:    o.Zin = 1'b0;
        endcase
      end
      S_T5: begin
        o.Zlowout = 1'b1;
        case (c)
          C_ALU, C_IMM: begin o.Gra = 1'b1; o.Rin = 1'b1; end
          C_LD, C_ST:   o.MARin = 1'b1;
          C_MUL:        o.LOin = 1'b1;
          default:      o.Zlowout = 1'b0;
        endcase
      end
      S_T6: begin
        case (c)
          C_LD:    begin o.Read = 1'b1; o.MDRin = 1'b1; end
          C_ST:    begin o.Gra = 1'b1; o.Rout = 1'b1; o.MDRin = 1'b1; end
          C_MUL:   begin o.Zhighout = 1'b1; o.HIin = 1'b1; end
          default: ;
        endcase
      end
      S_T7: begin
        case (c)
          C_LD:    begin o.MDRout = 1'b1; o.Gra = 1'b1; o.Rin = 1'b1; end
          C_ST:    o.Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
    return o;
  endfunction

  always_comb begin
    nxt_state = state;
    nxt_cls   = cls;
    nxt_op    = op_q;
    case (state)
      S_RESET: nxt_state = S_T0;
      S_T0:    nxt_state = S_T1;
      S_T1:    nxt_state = mem_wait ? S_T1 : S_T2;
      S_T2: begin
        nxt_cls = classify(ir[31:27]);
        nxt_op  = ir[31:27];
        case (nxt_cls)
          C_HALT:  nxt_state = S_HALT;
          C_NOP:   nxt_state = S_T0;
          default: nxt_state = S_T3;
        endcase
      end
      S_T3:    nxt_state = S_T4;
      S_T4:    nxt_state = S_T5;
      S_T5:    nxt_state = (cls == C_ALU || cls == C_IMM) ? S_T0 : S_T6;
      S_T6: begin
        if (cls == C_LD)      nxt_state = mem_wait ? S_T6 : S_T7;
        else if (cls == C_ST) nxt_state = S_T7;
        else                  nxt_state = S_T0;
      end
      S_T7: begin
        if (cls == C_ST) nxt_state = mem_wait ? S_T7 : S_T0;
        else             nxt_state = S_T0;
      end
      S_HALT:  nxt_state = S_HALT;
      default: nxt_state = S_RESET;
    endcase
  end

  // Outputs are registered from the next state so they line up with state.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= S_RESET;
      cls   <= C_NOP;
      op_q  <= 5'd0;
      ctrl  <= '0;
    end else begin
      state <= nxt_state;
      cls   <= nxt_cls;
      op_q  <= nxt_op;
      ctrl  <= decode(nxt_state, nxt_cls, nxt_op);
    end
  end

  assign PCout     = ctrl.PCout;
  assign IncPC     = ctrl.IncPC;
  assign PCin      = ctrl.PCin;
  assign MARin     = ctrl.MARin;
  assign MDRin     = ctrl.MDRin;
  assign MDRout    = ctrl.MDRout;
  assign Read      = ctrl.Read;
  assign Write     = ctrl.Write;
  assign IRin      = ctrl.IRin;
  assign Yin       = ctrl.Yin;
  assign Zin       = ctrl.Zin;
  assign Zlowout   = ctrl.Zlowout;
  assign Zhighout  = ctrl.Zhighout;
  assign HIin      = ctrl.HIin;
  assign LOin      = ctrl.LOin;
  assign Gra       = ctrl.Gra;
  assign Grb       = ctrl.Grb;
  assign Grc       = ctrl.Grc;
  assign Rin       = ctrl.Rin;
  assign Rout      = ctrl.Rout;
  assign BAout     = ctrl.BAout;
  assign Cout      = ctrl.Cout;
  assign OpCode    = ctrl.OpCode;
  assign run       = ctrl.run;
  assign dbg_state = state;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-instruction micro-step lists from a reference
// model, compared cycle by cycle against the strobe outputs.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] ir;
  logic        mem_ready;
  logic        PCout, IncPC, PCin, MARin, MDRin, MDRout, Read, Write, IRin;
  logic        Yin, Zin, Zlowout, Zhighout, HIin, LOin, Gra, Grb, Grc;
  logic        Rin, Rout, BAout, Cout, run;
  logic [4:0]  OpCode;
  logic [3:0]  dbg_state;

`ifdef CTRL_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  localparam logic [27:0] PCOUT = 28'h0000001, INCPC = 28'h0000002, PCIN  = 28'h0000004;
  localparam logic [27:0] MARIN = 28'h0000008, MDRIN = 28'h0000010, MDROUT = 28'h0000020;
  localparam logic [27:0] READ  = 28'h0000040, WRITE = 28'h0000080, IRIN  = 28'h0000100;
  localparam logic [27:0] YIN   = 28'h0000200, ZIN   = 28'h0000400, ZLOW  = 28'h0000800;
  localparam logic [27:0] ZHIGH = 28'h0001000, HIIN  = 28'h0002000, LOIN  = 28'h0004000;
  localparam logic [27:0] GRA   = 28'h0008000, GRB   = 28'h0010000, GRC   = 28'h0020000;
  localparam logic [27:0] RIN   = 28'h0040000, ROUT  = 28'h0080000, BAOUT = 28'h0100000;
  localparam logic [27:0] COUT  = 28'h0200000, RUN   = 28'h8000000;
  localparam logic [27:0] T0V   = RUN | PCOUT | MARIN | INCPC | ZIN;

  logic [27:0] obs;
  logic [27:0] exp_q[$];
  logic        mr_q[$];
  int          total = 0;
  int          bad = 0;

  control_unit dut (
    .clk(clk), .clr(clr), .ir(ir), .mem_ready(mem_ready),
    .PCout(PCout), .IncPC(IncPC), .PCin(PCin), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .Read(Read), .Write(Write), .IRin(IRin), .Yin(Yin),
    .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .Cout(Cout), .OpCode(OpCode), .run(run), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  assign obs = {run, OpCode, Cout, BAout, Rout, Rin, Grc, Grb, Gra, LOin, HIin,
                Zhighout, Zlowout, Zin, Yin, IRin, Write, Read, MDRout, MDRin,
                MARin, PCin, IncPC, PCout};

  // 0 nop/unlisted, 1 R-type, 2 immediate, 3 ld, 4 st, 5 mul/div, 6 halt
  function automatic int op_class(input logic [4:0] op);
    if (op >= 5'd3 && op <= 5'd10)  return 1;
    if (op >= 5'd12 && op <= 5'd14) return 2;
    if (op == 5'd0)                 return 3;
    if (op == 5'd2)                 return 4;
    if (op == 5'd15 || op == 5'd16) return 5;
    if (op == 5'd27)                return 6;
    return 0;
  endfunction

  task automatic push_step(input logic [27:0] v, input bit mem, input int waits);
    if (mem && WAIT_EN) begin
      for (int k = 0; k < waits; k++) begin
        exp_q.push_back(v);
        mr_q.push_back(1'b0);
      end
      exp_q.push_back(v);
      mr_q.push_back(1'b1);
    end else begin
      exp_q.push_back(v);
      mr_q.push_back(1'($urandom_range(0, 1)));
    end
  endtask

  task automatic build(input logic [4:0] op, input int w_fetch, input int w_mem);
    logic [27:0] opf;
    logic [27:0] addf;
    opf  = {1'b0, op, 22'd0};
    addf = {1'b0, 5'b00011, 22'd0};
    push_step(T0V, 1'b0, 0);
    push_step(RUN | ZLOW | PCIN | READ | MDRIN, 1'b1, w_fetch);
    push_step(RUN | MDROUT | IRIN, 1'b0, 0);
    case (op_class(op))
      1: begin
        push_step(RUN | GRB | ROUT | YIN, 1'b0, 0);
        push_step(RUN | GRC | ROUT | ZIN | opf, 1'b0, 0);
        push_step(RUN | ZLOW | GRA | RIN, 1'b0, 0);
      end
      2: begin
        push_step(RUN | GRB | ROUT | YIN, 1'b0, 0);
        push_step(RUN | COUT | ZIN | opf, 1'b0, 0);
        push_step(RUN | ZLOW | GRA | RIN, 1'b0, 0);
      end
      3, 4: begin
        push_step(RUN | GRB | BAOUT | YIN, 1'b0, 0);
        push_step(RUN | COUT | ZIN | addf, 1'b0, 0);
        push_step(RUN | ZLOW | MARIN, 1'b0, 0);
        if (op_class(op) == 3) begin
          push_step(RUN | READ | MDRIN, 1'b1, w_mem);
          push_step(RUN | MDROUT | GRA | RIN, 1'b0, 0);
        end else begin
          push_step(RUN | GRA | ROUT | MDRIN, 1'b0, 0);
          push_step(RUN | WRITE, 1'b1, w_mem);
        end
      end
      5: begin
        push_step(RUN | GRA | ROUT | YIN, 1'b0, 0);
        push_step(RUN | GRB | ROUT | ZIN | opf, 1'b0, 0);
        push_step(RUN | ZLOW | LOIN, 1'b0, 0);
        push_step(RUN | ZHIGH | HIIN, 1'b0, 0);
      end
      default: ;
    endcase
  endtask

  task automatic check(input string tag, input logic [27:0] e);
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic step_one(input string tag);
    check(tag, exp_q.pop_front());
    mem_ready = mr_q.pop_front();
    @(negedge clk);
  endtask

  task automatic run_queue(input string tag);
    while (exp_q.size() > 0) step_one(tag);
  endtask

  task automatic start_instr(input logic [4:0] op, input int w_fetch, input int w_mem);
    ir = {op, 27'($urandom)};
    build(op, w_fetch, w_mem);
  endtask

  task automatic reset_and_resume(input string tag);
    clr = 1'b1;
    exp_q.delete();
    mr_q.delete();
    @(negedge clk);
    check({tag, "_rst1"}, 28'd0);
    @(negedge clk);
    check({tag, "_rst2"}, 28'd0);
    clr = 1'b0;
    @(negedge clk);
    check({tag, "_t0"}, T0V);
  endtask

  initial begin
    logic [4:0] op;
    clr = 1'b1;
    ir = 32'd0;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state", 28'd0);
    clr = 1'b0;
    @(negedge clk);

    ir = 32'h18000000;
    build(5'b00011, 0, 0);
    run_queue("add");

    start_instr(5'b00000, 0, 3);
    run_queue("ld_wait");

    start_instr(5'b01111, 0, 0);
    run_queue("mul");

    start_instr(5'b10000, 2, 0);
    run_queue("div_fetch_wait");

    start_instr(5'b00010, 1, 2);
    run_queue("st_wait");

    start_instr(5'b11111, 0, 0);
    run_queue("op11111_nop");

    for (int n = 0; n < 40; n++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = 5'd26;
      start_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
      run_queue("random");
    end

    start_instr(5'b00000, 2, 2);
    for (int k = 0; k < 4; k++) step_one("ld_abort");
    reset_and_resume("mid_instr");

    start_instr(5'b11011, 1, 0);
    run_queue("halt_fetch");
    for (int k = 0; k < 6; k++) begin
      check("halt_hold", 28'd0);
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    reset_and_resume("halt");

    start_instr(5'b00001, 0, 0);
    run_queue("unlisted");
    check("final_t0", T0V);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
